// File: rtl/vpu_dst_port_pkg.sv
// Shared widths, depths and the FSM state type for the VPU destination
// (write-back) port.
package vpu_dst_port_pkg;

    localparam int OPERAND_WIDTH   = 32;
    localparam int SRAM_ADDR_WIDTH = 10;
    localparam int VEC_LEN_WIDTH   = 16;
    localparam int DST_FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        DST_IDLE = 2'd0,
        DST_RUN  = 2'd1,
        DST_DONE = 2'd2
    } dst_state_t;

endpackage

// File: rtl/vpu_dst_fifo.sv
// Small synchronous result buffer. The head is read combinationally and the
// pointers carry one extra wrap bit so full and empty can be told apart.
module vpu_dst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vpu_dst_port.sv
// VPU destination port: buffers ALU results and writes them to vector SRAM at
// sequential addresses from a latched base, then pulses done to the controller.
module vpu_dst_port
    import vpu_dst_port_pkg::*;
#(
    parameter int OPERAND_WIDTH = vpu_dst_port_pkg::OPERAND_WIDTH,
    parameter int ADDR_WIDTH    = vpu_dst_port_pkg::SRAM_ADDR_WIDTH,
    parameter int LEN_WIDTH     = vpu_dst_port_pkg::VEC_LEN_WIDTH,
    parameter int FIFO_DEPTH    = vpu_dst_port_pkg::DST_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [ADDR_WIDTH-1:0]    base_addr_i,
    input  logic [LEN_WIDTH-1:0]     vec_len_i,
    input  logic [OPERAND_WIDTH-1:0] result_i,
    input  logic                     result_valid_i,
    output logic                     result_ready_o,
    output logic                     sram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]    sram_wr_addr_o,
    output logic [OPERAND_WIDTH-1:0] sram_wr_data_o,
    input  logic                     sram_wr_ready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [LEN_WIDTH-1:0] CNT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    dst_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [LEN_WIDTH-1:0]     acc_cnt_q, acc_cnt_d;
    logic [LEN_WIDTH-1:0]     wr_cnt_q, wr_cnt_d;
    logic [LEN_WIDTH-1:0]     wr_cnt_inc;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [OPERAND_WIDTH-1:0] fifo_head;
    logic                     running;

    vpu_dst_fifo #(
        .WIDTH (OPERAND_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (result_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign running    = (state_q == DST_RUN);
    assign wr_cnt_inc = wr_cnt_q + CNT_ONE;

    // No bypass: a full FIFO refuses input even when it is draining this cycle.
    assign result_ready_o = running && (acc_cnt_q != len_q) && !fifo_full;
    assign sram_wr_en_o   = running && !fifo_empty;
    assign fifo_push      = result_valid_i && result_ready_o;
    assign fifo_pop       = sram_wr_en_o && sram_wr_ready_i;

    // Address and data are forced to zero whenever no write is requested.
    assign sram_wr_addr_o = sram_wr_en_o ? (base_q + ADDR_WIDTH'(wr_cnt_q)) : '0;
    assign sram_wr_data_o = sram_wr_en_o ? fifo_head : '0;

    assign busy_o = (state_q != DST_IDLE);
    assign done_o = (state_q == DST_DONE);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        unique case (state_q)
            DST_IDLE: begin
                if (start_i) begin
                    base_d    = base_addr_i;
                    len_d     = vec_len_i;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                    state_d   = (vec_len_i == '0) ? DST_DONE : DST_RUN;
                end
            end
            DST_RUN: begin
                if (fifo_push) begin
                    acc_cnt_d = acc_cnt_q + CNT_ONE;
                end
                if (fifo_pop) begin
                    wr_cnt_d = wr_cnt_inc;
                    if (wr_cnt_inc == len_q) begin
                        state_d = DST_DONE;
                    end
                end
            end
            DST_DONE: begin
                state_d = DST_IDLE;
            end
            default: begin
                state_d = DST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

endmodule
